// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak-f[1600] widths, SHAKE rates and squeeze FSM state encoding
package keccak_pkg;
    localparam int LANE_W              = 64;
    localparam int NUM_LANES           = 25;
    localparam int STATE_W             = LANE_W * NUM_LANES;
    localparam int SHAKE128_RATE_LANES = 21;
    localparam int SHAKE256_RATE_LANES = 17;
    typedef logic [LANE_W-1:0] lane_t;
    typedef enum logic [1:0] {IDLE, WAIT_STATE, SQUEEZE} sqz_state_t;
endpackage

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: captures a permuted state and streams its rate lanes, one lane per handshake.
// Optional word counter output enabled with `define KECCAK_SQZ_WORD_CNT_EN.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = SHAKE128_RATE_LANES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               start,
    input  logic               stop,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_valid,
    output logic               state_ready,
    output logic               perm_req,
    output logic [LANE_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [15:0]        block_cnt,
`ifdef KECCAK_SQZ_WORD_CNT_EN
    output logic [31:0]        word_cnt,
`endif
    output logic               busy
);
    localparam int IDX_W = $clog2(RATE_LANES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

    sqz_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             perm_q, perm_d;
    logic [15:0]      blk_q, blk_d;
    logic             cap;
    logic             last;
    lane_t            buf_q [RATE_LANES];
`ifdef KECCAK_SQZ_WORD_CNT_EN
    logic [31:0]      wcnt_q, wcnt_d;
    assign word_cnt = wcnt_q;
`endif

    // Capacity lanes are deliberately never stored.
    logic unused_cap;
    assign unused_cap = ^state_in[STATE_W-1:RATE_LANES*LANE_W];

    assign last        = idx_q == LAST_IDX;
    assign busy        = state_q != IDLE;
    assign state_ready = enable && state_q == WAIT_STATE;
    assign out_valid   = enable && state_q == SQUEEZE;
    assign out_last    = state_q == SQUEEZE && last;
    assign perm_req    = enable && perm_q;
    assign out_data    = buf_q[idx_q];
    assign block_cnt   = blk_q;

    // Next-state logic; nothing moves while enable is low, and stop overrides every other event.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        perm_d  = perm_q;
        blk_d   = blk_q;
        cap     = 1'b0;
`ifdef KECCAK_SQZ_WORD_CNT_EN
        wcnt_d  = wcnt_q;
`endif
        if (enable) begin
            perm_d = 1'b0;
            if (stop) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_d = WAIT_STATE;
                        blk_d   = '0;
`ifdef KECCAK_SQZ_WORD_CNT_EN
                        wcnt_d  = '0;
`endif
                    end
                    WAIT_STATE: if (state_valid) begin
                        cap     = 1'b1;
                        idx_d   = '0;
                        state_d = SQUEEZE;
                    end
                    SQUEEZE: if (out_ready) begin
`ifdef KECCAK_SQZ_WORD_CNT_EN
                        wcnt_d = wcnt_q + 32'(wcnt_q != 32'hFFFF_FFFF);
`endif
                        if (last) begin
                            idx_d   = '0;
                            state_d = WAIT_STATE;
                            perm_d  = 1'b1;
                            blk_d   = blk_q + 16'(blk_q != 16'hFFFF);
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            perm_q  <= 1'b0;
            blk_q   <= '0;
`ifdef KECCAK_SQZ_WORD_CNT_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            perm_q  <= perm_d;
            blk_q   <= blk_d;
`ifdef KECCAK_SQZ_WORD_CNT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    // Rate-lane buffer, loaded in one shot when a new state is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RATE_LANES; i++) buf_q[i] <= '0;
        end else if (cap) begin
            for (int i = 0; i < RATE_LANES; i++) buf_q[i] <= state_in[i*LANE_W +: LANE_W];
        end
    end
endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze: randomized lane-stream bench for keccak_squeeze (SHAKE128 and SHAKE256 instances)
module tb_keccak_squeeze;
    import keccak_pkg::*;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b1, start = 1'b0, stop = 1'b0;
    logic state_valid = 1'b0, out_ready = 1'b0;
    logic [STATE_W-1:0] state_in = '0;
    logic sr0, pr0, ov0, ol0, bz0, sr1, pr1, ov1, ol1, bz1;
    lane_t od0, od1;
    logic [15:0] bc0, bc1;
`ifdef KECCAK_SQZ_WORD_CNT_EN
    logic [31:0] wc0, wc1, o_wc;
`endif
    int sel = 0;
    logic o_sready, o_perm, o_valid, o_last, o_busy;
    lane_t o_data;
    logic [15:0] o_blk;

    assign o_sready = (sel != 0) ? sr1 : sr0;
    assign o_perm   = (sel != 0) ? pr1 : pr0;
    assign o_valid  = (sel != 0) ? ov1 : ov0;
    assign o_last   = (sel != 0) ? ol1 : ol0;
    assign o_busy   = (sel != 0) ? bz1 : bz0;
    assign o_data   = (sel != 0) ? od1 : od0;
    assign o_blk    = (sel != 0) ? bc1 : bc0;
`ifdef KECCAK_SQZ_WORD_CNT_EN
    assign o_wc     = (sel != 0) ? wc1 : wc0;
`endif

    always #5 clk = ~clk;

    keccak_squeeze #(.RATE_LANES(SHAKE128_RATE_LANES)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
        .state_in(state_in), .state_valid(state_valid), .state_ready(sr0),
        .perm_req(pr0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .out_last(ol0), .block_cnt(bc0),
`ifdef KECCAK_SQZ_WORD_CNT_EN
        .word_cnt(wc0),
`endif
        .busy(bz0));

    keccak_squeeze #(.RATE_LANES(SHAKE256_RATE_LANES)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
        .state_in(state_in), .state_valid(state_valid), .state_ready(sr1),
        .perm_req(pr1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .out_last(ol1), .block_cnt(bc1),
`ifdef KECCAK_SQZ_WORD_CNT_EN
        .word_cnt(wc1),
`endif
        .busy(bz1));

    // Reference model: expected lane stream plus simple counters.
    lane_t       exp_q [$];
    int          lane_n = 0, n_xfer = 0, n_perm = 0, n_cmp = 0, n_err = 0;
    logic        pend = 1'b0, hold = 1'b0, exp_idle = 1'b0;
    lane_t       hold_data = '0;
    logic [15:0] m_blk = '0;
    logic [31:0] m_words = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [STATE_W-1:0] rand_state();
        logic [STATE_W-1:0] s;
        for (int i = 0; i < NUM_LANES; i++) s[i*LANE_W +: LANE_W] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic flush();
        exp_q.delete();
        lane_n = 0;
        hold = 1'b0;
    endtask

    task automatic cycle();
        logic xf, cap;
        int rl;
        lane_t e;
        rl = (sel != 0) ? SHAKE256_RATE_LANES : SHAKE128_RATE_LANES;
        @(negedge clk);
        xf  = enable && !stop && o_valid && out_ready;
        cap = enable && !stop && o_sready && state_valid;
        chk("perm_req", 64'(o_perm), 64'(pend && enable));
        if (pend && enable) chk("ready_after_perm", 64'(o_sready), 64'd1);
        if (o_perm) n_perm++;
        if (enable) pend = 1'b0;
        chk("block_cnt", 64'(o_blk), 64'(m_blk));
`ifdef KECCAK_SQZ_WORD_CNT_EN
        chk("word_cnt", 64'(o_wc), 64'(m_words));
`endif
        if (!enable) begin
            chk("frozen_valid", 64'(o_valid), 64'd0);
            chk("frozen_ready", 64'(o_sready), 64'd0);
        end
        if (exp_idle) begin
            chk("idle_busy", 64'(o_busy), 64'd0);
            chk("idle_ready", 64'(o_sready), 64'd0);
        end
        if (enable) begin
            if (hold) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_data", o_data, hold_data);
            end
            hold = !stop && o_valid && !out_ready;
            hold_data = o_data;
        end
        if (xf) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = ~o_data;
            chk("lane_data", o_data, e);
            chk("out_last", 64'(o_last), 64'(lane_n == rl - 1));
            n_xfer++;
            lane_n++;
            m_words += 32'(m_words != 32'hFFFF_FFFF);
            if (lane_n == rl) begin
                lane_n = 0;
                pend = 1'b1;
                m_blk += 16'(m_blk != 16'hFFFF);
            end
        end
        if (cap) for (int i = 0; i < rl; i++) exp_q.push_back(state_in[i*LANE_W +: LANE_W]);
        @(posedge clk);
        #1;
        if (cap) state_in = rand_state();
    endtask

    // mode 0: out_ready high, 1: pattern 1,0,0,1, 2: random
    task automatic run(input int beats, input int mode, input int budget, output int c);
        int t0;
        t0 = n_xfer;
        c = 0;
        while (n_xfer - t0 < beats && c < budget) begin
            out_ready = (mode == 0) ? 1'b1 :
                        (mode == 1) ? ((c % 4) == 0 || (c % 4) == 3) : 1'($urandom_range(0, 1));
            cycle();
            c++;
        end
        if (c >= budget) chk("timeout_beats", 64'(n_xfer - t0), 64'(beats));
    endtask

    task automatic begin_session(input int s);
        sel = s;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        flush();
        start = 1'b1;
        cycle();
        start = 1'b0;
        m_blk = '0;
        m_words = '0;
    endtask

    task automatic model_reset();
        flush();
        pend = 1'b0;
        m_blk = '0;
        m_words = '0;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("hard_reset_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        int c, p0;
        lane_t fd;
        #1 rst = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_valid", 64'(o_valid), 64'd0);
            chk("rst_data", o_data, 64'd0);
            chk("rst_last", 64'(o_last), 64'd0);
            chk("rst_perm", 64'(o_perm), 64'd0);
            chk("rst_blk", 64'(o_blk), 64'd0);
            chk("rst_busy", 64'(o_busy), 64'd0);
            chk("rst_ready", 64'(o_sready), 64'd0);
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // SHAKE128 stream with a known lane pattern
        begin_session(0);
        for (int i = 0; i < NUM_LANES; i++) state_in[i*LANE_W +: LANE_W] = 64'hC0DE_0000_0000_0000 + 64'(i);
        state_valid = 1'b1;
        out_ready = 1'b1;
        p0 = n_perm;
        run(21, 0, 100, c);
        chk("stream_cycles", 64'(c), 64'd22);
        cycle();
        cycle();
        chk("stream_perm_pulses", 64'(n_perm - p0), 64'd1);
        chk("stream_block_cnt", 64'(o_blk), 64'd1);

        // backpressure 1,0,0,1 over two more blocks
        run(42, 1, 600, c);
        cycle();
        chk("bp_block_cnt", 64'(o_blk), 64'd3);

        // abort at lane 9 of the second block
        begin_session(0);
        run(30, 0, 200, c);
        p0 = n_perm;
        stop = 1'b1;
        out_ready = 1'b1;
        cycle();
        stop = 1'b0;
        flush();
        exp_idle = 1'b1;
        cycle();
        cycle();
        exp_idle = 1'b0;
        chk("abort_no_perm", 64'(n_perm - p0), 64'd0);
        chk("abort_blk_held", 64'(o_blk), 64'd1);
        begin_session(0);
        chk("abort_restart_blk", 64'(o_blk), 64'd0);

        // enable freeze at lane 4
        run(4, 0, 100, c);
        enable = 1'b0;
        fd = o_data;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("freeze_data", o_data, fd);
`ifdef KECCAK_SQZ_WORD_CNT_EN
            chk("freeze_word_cnt", 64'(o_wc), 64'd4);
`endif
        end
        enable = 1'b1;
        run(1, 0, 10, c);
        chk("freeze_resume_cycles", 64'(c), 64'd1);

        // SHAKE256 multi-block with random backpressure
        hard_reset();
        begin_session(1);
        state_in = rand_state();
        p0 = n_perm;
        run(51, 2, 1500, c);
        cycle();
        chk("multi_perm_pulses", 64'(n_perm - p0), 64'd3);
        chk("multi_block_cnt", 64'(o_blk), 64'd3);

        // asynchronous reset mid-squeeze
        begin_session(1);
        run(5, 0, 100, c);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_data", o_data, 64'd0);
        chk("arst_last", 64'(o_last), 64'd0);
        chk("arst_perm", 64'(o_perm), 64'd0);
        chk("arst_blk", 64'(o_blk), 64'd0);
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_ready", 64'(o_sready), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_idle = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        exp_idle = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
- Squeeze-side reader for the Keccak permutation core.
- Captures a permuted 1600-bit state and streams its rate lanes out one 64-bit lane per handshake, lane 0 first.
- When the rate is exhausted it pulses a request for the next permutation, then waits for the new state.
- Feeds XOF output (SHAKE128/SHAKE256) to the Kyber sampling logic.

Parameters:
- RATE_LANES, 21, lanes squeezed per block (21 = SHAKE128, 17 = SHAKE256); legal range 1..24.
- LANE_W, 64, lane width in bits; fixed by Keccak-f[1600].

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  global advance enable; low freezes all state.
- start  input  1  begin a new squeeze session; clears block count.
- stop  input  1  synchronous abort; return to IDLE.
- state_in  input  1600  permuted state; lane i = state_in[i*64 +: 64].
- state_valid  input  1  state_in holds a valid permuted state.
- state_ready  output  1  block can capture state_in this cycle.
- perm_req  output  1  one-cycle pulse: run the next permutation.
- out_data  output  64  current lane.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  current lane is lane RATE_LANES-1.
- block_cnt  output  16  completed blocks this session; saturates at 16'hFFFF.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM in IDLE; lane index 0; lane buffer 0.
  - out_data 0, out_valid 0, out_last 0, perm_req 0, block_cnt 0, busy 0, state_ready 0.
- FSM states: IDLE, WAIT_STATE, SQUEEZE.
- IDLE:
  - state_ready 0, out_valid 0.
  - start && enable -> WAIT_STATE; block_cnt cleared.
- WAIT_STATE:
  - state_ready = enable.
  - state_valid && state_ready -> capture lanes 0..RATE_LANES-1 into the lane buffer; index set to 0; next state SQUEEZE.
  - Only rate lanes are stored; the capacity lanes are never held.
- SQUEEZE:
  - out_valid = enable; out_data = buffer[index], driven from registers.
  - out_last = (index == RATE_LANES-1).
  - Transfer occurs when out_valid && out_ready.
  - Transfer with index < RATE_LANES-1 -> index+1.
  - Transfer on the last lane -> perm_req = 1 in the next cycle for exactly one cycle; block_cnt+1 (saturating); index reset to 0; next state WAIT_STATE.
  - state_ready is 0 throughout SQUEEZE; state_valid is ignored.
- Latency:
  - Capture edge -> lane 0 on out_data/out_valid in the following cycle.
  - Steady state: one lane per cycle while out_ready is held high.
  - Last-lane transfer -> WAIT_STATE and perm_req in the next cycle.
- enable low:
  - No state, index, buffer or counter change.
  - out_valid, state_ready and perm_req forced 0.
  - out_data holds its value.
- stop (sampled only when enable is high):
  - From any state -> IDLE, index 0.
  - No perm_req; block_cnt held; buffer contents unchanged.
- Simultaneous events:
  - stop with a transfer: stop wins; the lane is not counted and no perm_req is issued.
  - stop with start: stop wins.
  - start while busy: ignored.
- Reset mid-squeeze: immediate return to reset values; the partial block is discarded.

Optional Feature:
- Macro: KECCAK_SQZ_WORD_CNT_EN.
- Defined: adds output port word_cnt [31:0].
  - Counts every lane transfer since the last start; cleared on start; saturates at 32'hFFFF_FFFF.
  - Reset value 0; frozen when enable is low.
- Undefined: port absent and no counter logic; all other behaviour identical.

Decomposition:
- Shared package keccak_pkg holds:
  - LANE_W = 64, NUM_LANES = 25, STATE_W = 1600.
  - SHAKE128_RATE_LANES = 21, SHAKE256_RATE_LANES = 17.
  - typedef lane_t (logic [63:0]).
  - enum sqz_state_t {IDLE, WAIT_STATE, SQUEEZE}.
- No sub-module: the buffer, lane mux and FSM stay inline.

Test Plan:
- Stream, SHAKE128: RATE_LANES=21; state lane i = 64'hC0DE_0000_0000_0000 + i; out_ready held 1.
  - 21 consecutive beats 64'hC0DE_0000_0000_0000..+20, out_last on beat 21.
  - perm_req pulses for 1 cycle after beat 21; block_cnt = 1; state_ready high the next cycle.
- Backpressure: toggle out_ready 1,0,0,1.
  - out_data and out_valid stay stable while out_ready is 0; no lane skipped or duplicated; order preserved.
- Multi-block, SHAKE256: RATE_LANES=17; supply 3 states with distinct patterns.
  - 51 beats total; exactly 3 perm_req pulses; block_cnt = 3.
  - Capacity lanes 17..24 never appear on out_data.
- Abort: assert stop at lane 9 with out_ready = 1.
  - Lane 9 not consumed; next cycle busy 0; no perm_req; block_cnt unchanged.
  - Then start -> block_cnt 0.
- Enable freeze: drop enable for 5 cycles in SQUEEZE at lane 4.
  - out_valid 0 during the freeze; on re-enable, lane 4 is presented again.
  - With KECCAK_SQZ_WORD_CNT_EN defined, word_cnt = 4 throughout the freeze.
- Async reset: pulse rst low mid-cycle during SQUEEZE.
  - All outputs go to reset values immediately without waiting for a clock edge.
  - After release, state_ready stays 0 until start.
